// File: rtl/uart2wb_pkg.sv
// Shared codes and state encoding for the UART-driven Wishbone initiator.
// Command/reply bytes are the host protocol's wire values.
package uart2wb_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR   = 8'h3F;  // '?'
  localparam logic [7:0] RSP_TMO   = 8'h54;  // 'T'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_e;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart2wb.sv
// Host-over-UART Wishbone initiator: decodes W/R byte commands, runs one
// classic bus cycle with an ack timeout, and streams the reply bytes back.
module uart2wb
  import uart2wb_pkg::*;
#(
  parameter int addr_width     = 32,
  parameter int data_width     = 32,
  parameter int timeout_cycles = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [addr_width-1:0]   wb_adr,
  output logic [data_width-1:0]   wb_datwr,
  input  logic [data_width-1:0]   wb_datrd,
  output logic                    wb_we,
  output logic                    wb_stb,
  input  logic                    wb_ack,
  output logic                    wb_cyc,
  output logic [data_width/8-1:0] wb_sel,
  output logic                    busy
);

  localparam int TW = $clog2(timeout_cycles + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(timeout_cycles - 1);

  state_e                  state_q, state_d;
  logic                    is_wr_q, is_wr_d;
  logic                    multi_q, multi_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [addr_width-1:0]   adr_q, adr_d;
  logic [data_width-1:0]   datwr_q, datwr_d;
  logic [data_width-1:0]   rdat_q, rdat_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    cyc_q, cyc_d;
  logic                    we_q, we_d;

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    multi_d    = multi_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    adr_d      = adr_q;
    datwr_d    = datwr_q;
    rdat_d     = rdat_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    case (state_q)
      ST_IDLE: if (rx_valid) begin
        cnt_d = '0;
        if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
          is_wr_d = (rx_data == CMD_WRITE);
          state_d = ST_ADDR;
        end else begin
          state_d    = ST_RESP;
          tx_valid_d = 1'b1;
          tx_data_d  = RSP_ERR;
          multi_d    = 1'b0;
        end
      end
      ST_ADDR: if (rx_valid) begin
        adr_d[{cnt_q, 3'b000} +: 8] = rx_data;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          if (is_wr_q) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_BUS;
            cyc_d   = 1'b1;
            we_d    = 1'b0;
            tmo_d   = '0;
          end
        end
      end
      ST_DATA: if (rx_valid) begin
        datwr_d[{cnt_q, 3'b000} +: 8] = rx_data;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = ST_BUS;
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          tmo_d   = '0;
        end
      end
      ST_BUS: begin
        // An ack on the final allowed cycle still wins over the abort.
        if (wb_ack) begin
          state_d    = ST_RESP;
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          tx_valid_d = 1'b1;
          cnt_d      = '0;
          multi_d    = !is_wr_q;
          if (is_wr_q) begin
            tx_data_d = RSP_OK;
          end else begin
            rdat_d    = wb_datrd;
            tx_data_d = wb_datrd[7:0];
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d    = ST_RESP;
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          tx_valid_d = 1'b1;
          tx_data_d  = RSP_TMO;
          cnt_d      = '0;
          multi_d    = 1'b0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_RESP: if (tx_ready) begin
        if (!multi_q || cnt_q == 2'd3) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d     = cnt_q + 2'd1;
          tx_data_d = word_byte(rdat_q[31:0], cnt_q + 2'd1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      is_wr_q    <= 1'b0;
      multi_q    <= 1'b0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      adr_q      <= '0;
      datwr_q    <= '0;
      rdat_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      multi_q    <= multi_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      adr_q      <= adr_d;
      datwr_q    <= datwr_d;
      rdat_q     <= rdat_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign wb_adr   = adr_q;
  assign wb_datwr = datwr_q;
  assign wb_we    = we_q;
  assign wb_cyc   = cyc_q;
  assign wb_stb   = cyc_q;
  assign wb_sel   = cyc_q ? '1 : '0;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart2wb.sv
// Bench for uart2wb: protocol-level model (expected bus cycles and reply
// bytes queued per command) checked every cycle, plus literal spot checks.
module tb_uart2wb;

  localparam int TMO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] wb_adr, wb_datwr, wb_datrd;
  logic        wb_we, wb_stb, wb_ack, wb_cyc;
  logic [3:0]  wb_sel;
  logic        busy;

  uart2wb #(.addr_width(32), .data_width(32), .timeout_cycles(TMO)) dut (
    .clock(clock), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_adr(wb_adr), .wb_datwr(wb_datwr), .wb_datrd(wb_datrd),
    .wb_we(wb_we), .wb_stb(wb_stb), .wb_ack(wb_ack), .wb_cyc(wb_cyc),
    .wb_sel(wb_sel), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    int          len;
  } bus_t;

  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  logic [7:0] tx_log[$];
  bus_t       cur;
  bit         in_cyc;
  int         cyc_len;
  int         stb_age;
  int         ack_delay;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor(input bit xfer, input logic [7:0] xd, input bit acked,
                         input bit held, input logic [7:0] hd);
    if (acked) begin
      chk("ack_to_txvalid", 32'(tx_valid), 1);
      chk("ack_drops_stb", 32'(wb_stb), 0);
    end
    if (held) begin
      chk("hold_valid", 32'(tx_valid), 1);
      chk("hold_data", 32'(tx_data), 32'(hd));
    end
    if (xfer) begin
      tx_log.push_back(xd);
      if (exp_tx.size() == 0) chk("tx_unexpected_depth", 32'(exp_tx.size()), 1);
      else chk("tx_byte", 32'(xd), 32'(exp_tx.pop_front()));
    end
    chk("cyc_eq_stb", 32'(wb_cyc), 32'(wb_stb));
    if (wb_stb) begin
      chk("sel", 32'(wb_sel), 32'hF);
      if (!in_cyc) begin
        if (exp_bus.size() == 0) chk("bus_unexpected_depth", 32'(exp_bus.size()), 1);
        else begin
          cur = exp_bus.pop_front();
          in_cyc = 1'b1;
          cyc_len = 0;
        end
      end
      if (in_cyc) begin
        chk("bus_adr", wb_adr, cur.adr);
        chk("bus_we", 32'(wb_we), 32'(cur.we));
        if (cur.we) chk("bus_dat", wb_datwr, cur.dat);
        cyc_len++;
      end
    end else if (in_cyc) begin
      chk("cyc_len", 32'(cyc_len), 32'(cur.len));
      in_cyc = 1'b0;
    end
  endtask

  // Slave: ack after ack_delay stb cycles (0 = zero-wait), never if negative.
  task automatic slave_drive();
    if (wb_stb) begin
      wb_ack = (ack_delay >= 0 && stb_age == ack_delay);
      stb_age++;
    end else begin
      wb_ack = 1'b0;
      stb_age = 0;
    end
  endtask

  task automatic tick();
    bit xfer, acked, held;
    logic [7:0] xd;
    xfer  = tx_valid && tx_ready;
    held  = tx_valid && !tx_ready;
    xd    = tx_data;
    acked = wb_stb && wb_ack;
    @(posedge clock);
    @(negedge clock);
    monitor(xfer, xd, acked, held, xd);
    slave_drive();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic run_write(input logic [31:0] a, input logic [31:0] d, input int dly);
    bus_t e;
    e.adr = a; e.dat = d; e.we = 1'b1; e.len = (dly < 0) ? TMO : dly + 1;
    exp_bus.push_back(e);
    exp_tx.push_back((dly < 0) ? 8'h54 : 8'h4B);
    ack_delay = dly;
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    chk("w_stb_latency", 32'(wb_stb), 1);
  endtask

  task automatic run_read(input logic [31:0] a, input int dly);
    bus_t e;
    e.adr = a; e.dat = '0; e.we = 1'b0; e.len = (dly < 0) ? TMO : dly + 1;
    exp_bus.push_back(e);
    if (dly < 0) exp_tx.push_back(8'h54);
    else for (int i = 0; i < 4; i++) exp_tx.push_back(wb_datrd[8*i +: 8]);
    ack_delay = dly;
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    chk("r_stb_latency", 32'(wb_stb), 1);
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((busy || in_cyc || exp_tx.size() != 0) && n < lim);
    chk({name, "_idle"}, {30'b0, busy, in_cyc}, 0);
    chk({name, "_txq"}, 32'(exp_tx.size()), 0);
  endtask

  initial begin
    int n;
    reset = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1;
    wb_ack = 1'b0; wb_datrd = '0; ack_delay = -1; in_cyc = 1'b0; stb_age = 0;
    repeat (2) @(negedge clock);
    chk("rst_cyc", 32'(wb_cyc), 0);
    chk("rst_stb", 32'(wb_stb), 0);
    chk("rst_we", 32'(wb_we), 0);
    chk("rst_txv", 32'(tx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_adr", wb_adr, 0);
    chk("rst_dat", wb_datwr, 0);
    chk("rst_txd", 32'(tx_data), 0);
    reset = 1'b1;
    tick();

    // Write with ack after 2 wait cycles
    tx_log.delete();
    run_write(32'h0000_0010, 32'hDEAD_BEEF, 2);
    chk("w_adr_lit", wb_adr, 32'h0000_0010);
    chk("w_dat_lit", wb_datwr, 32'hDEAD_BEEF);
    chk("w_we_lit", 32'(wb_we), 1);
    chk("w_sel_lit", 32'(wb_sel), 32'hF);
    wait_idle("write", 100);
    chk("w_reply_lit", 32'(tx_log.size() > 0 ? tx_log[0] : 8'h00), 32'h4B);

    // Read returning 0x12345678
    tx_log.delete();
    wb_datrd = 32'h1234_5678;
    run_read(32'h0000_0020, 1);
    chk("r_adr_lit", wb_adr, 32'h0000_0020);
    chk("r_we_lit", 32'(wb_we), 0);
    wait_idle("read", 100);
    chk("r_len_lit", 32'(tx_log.size()), 4);
    if (tx_log.size() == 4) begin
      chk("r_b0_lit", 32'(tx_log[0]), 32'h78);
      chk("r_b1_lit", 32'(tx_log[1]), 32'h56);
      chk("r_b2_lit", 32'(tx_log[2]), 32'h34);
      chk("r_b3_lit", 32'(tx_log[3]), 32'h12);
    end

    // Unknown command byte
    tx_log.delete();
    exp_tx.push_back(8'h3F);
    send_byte(8'h41);
    wait_idle("badcmd", 50);
    chk("bad_reply_lit", 32'(tx_log.size() > 0 ? tx_log[0] : 8'h00), 32'h3F);
    chk("bad_busy", 32'(busy), 0);

    // Timeout, then a late ack that must be ignored
    tx_log.delete();
    run_read(32'h0000_0030, -1);
    wait_idle("tmo", 100);
    chk("tmo_reply_lit", 32'(tx_log.size() > 0 ? tx_log[0] : 8'h00), 32'h54);
    wb_ack = 1'b1;
    tick();
    repeat (3) tick();
    chk("late_ack_busy", 32'(busy), 0);
    chk("late_ack_txv", 32'(tx_valid), 0);
    wb_datrd = 32'hCAFE_F00D;
    run_read(32'h0000_0040, 0);
    wait_idle("zero_wait", 100);

    // Backpressure on read reply with an overrun rx byte
    tx_log.delete();
    tx_ready = 1'b0;
    wb_datrd = 32'h1234_5678;
    run_read(32'h0000_0050, 1);
    n = 0;
    while (!tx_valid && n < 20) begin tick(); n++; end
    chk("bp_txv", 32'(tx_valid), 1);
    repeat (20) tick();
    send_byte(8'h57);
    repeat (29) tick();
    chk("bp_hold_lit", 32'(tx_data), 32'h78);
    chk("bp_busy", 32'(busy), 1);
    tx_ready = 1'b1;
    wait_idle("bp", 100);
    chk("bp_len", 32'(tx_log.size()), 4);
    if (tx_log.size() == 4) chk("bp_word", {tx_log[3], tx_log[2], tx_log[1], tx_log[0]}, 32'h1234_5678);
    run_write(32'h0000_0060, 32'h0BAD_CAFE, 0);
    wait_idle("after_bp", 100);

    // Async reset while the bus cycle is pending
    run_write(32'h0000_0070, 32'h1122_3344, -1);
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_cyc", 32'(wb_cyc), 0);
    chk("arst_stb", 32'(wb_stb), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_txv", 32'(tx_valid), 0);
    exp_bus.delete();
    exp_tx.delete();
    in_cyc = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    wb_ack = 1'b0;
    tick();
    tx_log.delete();
    wb_datrd = 32'hA5A5_5A5A;
    run_read(32'h0000_0080, 2);
    wait_idle("post_rst", 100);
    chk("post_rst_len", 32'(tx_log.size()), 4);
    if (tx_log.size() == 4) chk("post_rst_word", {tx_log[3], tx_log[2], tx_log[1], tx_log[0]}, 32'hA5A5_5A5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
